// File: rtl/axis_skid_buf_if.sv
// axis_if: AXI4-Stream valid/ready/data bundle with master (m) and slave (s) views
interface axis_if #(parameter int TDATA_WIDTH = 8);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXI4-Stream skid buffer, fully registered in both directions.
// Define AXIS_SKID_BUF_INVALIDATE_EN to make the invalidate input flush both entries.
module axis_skid_buf (
    input  logic clk,
    input  logic rst_n,
    axis_if.s    axis_sif,
    axis_if.m    axis_mif,
    input  logic invalidate
);
    localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;

    if (TDATA_WIDTH <= 0 || axis_sif.TDATA_WIDTH != axis_mif.TDATA_WIDTH) begin : g_bad_width
        $fatal(1, "axis_skid_buf: TDATA_WIDTH must be >0 and equal on both streams");
    end

    // bit0 = out_valid, bit1 = skid_valid, so 2'b10 is never produced
    typedef enum logic [1:0] {EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b11} state_e;

    state_e                 state_q, state_d;
    logic                   tready_q, tready_d;
    logic [TDATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
    logic                   in_hs, out_hs, flush;

`ifdef AXIS_SKID_BUF_INVALIDATE_EN
    assign flush = invalidate;
`else
    logic unused_invalidate;
    assign unused_invalidate = invalidate;
    assign flush = 1'b0;
`endif

    assign in_hs           = axis_sif.tvalid & tready_q;
    assign out_hs          = state_q[0] & axis_mif.tready;
    assign axis_sif.tready = tready_q;
    assign axis_mif.tvalid = state_q[0];
    assign axis_mif.tdata  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_hs) begin
                state_d = BUSY;
                out_d   = axis_sif.tdata;
            end
            BUSY: if (in_hs && !out_hs) begin
                state_d = FULL;
                skid_d  = axis_sif.tdata;
            end else if (in_hs) begin
                out_d = axis_sif.tdata;
            end else if (out_hs) begin
                state_d = EMPTY;
            end
            FULL: if (out_hs) begin
                state_d = BUSY;
                out_d   = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        tready_d = state_d != FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            tready_q <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            out_q    <= out_d;
            skid_q   <= skid_d;
        end
    end
endmodule

// File: tb/tb_axis_skid_buf.sv
// tb_axis_skid_buf: directed and scoreboarded checks of the skid buffer (both invalidate builds)
module tb_axis_skid_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic invalidate = 1'b0;
    int   errors = 0;
    int   checks = 0;

    axis_if #(.TDATA_WIDTH(8)) sif ();
    axis_if #(.TDATA_WIDTH(8)) mif ();

    axis_skid_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axis_sif   (sif),
        .axis_mif   (mif),
        .invalidate (invalidate)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        sif.tvalid = 1'b0;
        sif.tdata  = 8'h00;
        mif.tready = 1'b0;
        repeat (2) tick();
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b want 0", mif.tvalid); end
        checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL reset_sready: got %b want 0", sif.tready); end
        checks++; if (mif.tdata !== 8'h00) begin errors++; $display("FAIL reset_mdata: got %h want 00", mif.tdata); end
    endtask

    task automatic test_first_beat;
        sif.tvalid = 1'b1;
        sif.tdata  = 8'hA5;
        mif.tready = 1'b1;
        rst_n      = 1'b1;
        tick();
        checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL first_sready: got %b want 1", sif.tready); end
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL first_novalid: got %b want 0", mif.tvalid); end
        tick();
        sif.tvalid = 1'b0;
        checks++; if (mif.tvalid !== 1'b1) begin errors++; $display("FAIL first_mvalid: got %b want 1", mif.tvalid); end
        checks++; if (mif.tdata !== 8'hA5) begin errors++; $display("FAIL first_mdata: got %h want a5", mif.tdata); end
        tick();
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b want 0", mif.tvalid); end
    endtask

    task automatic test_stream;
        mif.tready = 1'b1;
        sif.tvalid = 1'b1;
        sif.tdata  = 8'h01;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 8'(k + 1)) begin errors++; $display("FAIL stream_out%0d: got v=%b d=%h want v=1 d=%h", k, mif.tvalid, mif.tdata, 8'(k + 1)); end
            checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL stream_sready%0d: got %b want 1", k, sif.tready); end
            if (k < 15) sif.tdata = 8'(k + 2);
            else sif.tvalid = 1'b0;
        end
        tick();
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b want 0", mif.tvalid); end
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b);
        mif.tready = 1'b0;
        sif.tvalid = 1'b1;
        sif.tdata  = a;
        tick();
        sif.tdata  = b;
        tick();
        sif.tvalid = 1'b0;
        checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL fill_sready: got %b want 0", sif.tready); end
        checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== a) begin errors++; $display("FAIL fill_head: got v=%b d=%h want v=1 d=%h", mif.tvalid, mif.tdata, a); end
    endtask

    task automatic test_backpressure;
        fill(8'h11, 8'h22);
        repeat (2) begin
            tick();
            checks++; if (mif.tdata !== 8'h11 || mif.tvalid !== 1'b1) begin errors++; $display("FAIL bp_stable: got v=%b d=%h want v=1 d=11", mif.tvalid, mif.tdata); end
        end
        mif.tready = 1'b1;
        tick();
        checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 8'h22) begin errors++; $display("FAIL bp_second: got v=%b d=%h want v=1 d=22", mif.tvalid, mif.tdata); end
        checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL bp_sready: got %b want 1", sif.tready); end
        tick();
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", mif.tvalid); end
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        logic [7:0] prev_data = 8'h00;
        logic       prev_stall = 1'b0;
        logic       last_in_hs = 1'b0;
        int         sent = 0;
        int         rcvd = 0;
        int         cyc = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            tick();
            cyc++;
            if (prev_stall) begin
                checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== prev_data) begin errors++; $display("FAIL rnd_stable: got v=%b d=%h want v=1 d=%h", mif.tvalid, mif.tdata, prev_data); end
            end
            if (!sif.tvalid || last_in_hs) begin
                sif.tvalid = (sent < 1000) && ($urandom_range(1) == 1);
                sif.tdata  = sent[7:0];
            end
            mif.tready = (sent >= 1000) || ($urandom_range(1) == 1);
            last_in_hs = sif.tvalid && sif.tready;
            if (last_in_hs) begin
                q.push_back(sif.tdata);
                sent++;
            end
            if (mif.tvalid && mif.tready) begin
                checks++; if (q.size() == 0 || mif.tdata !== q[0]) begin errors++; $display("FAIL rnd_order%0d: got %h want %h", rcvd, mif.tdata, q.size() ? q[0] : 8'hxx); end
                if (q.size() != 0) void'(q.pop_front());
                rcvd++;
            end
            prev_stall = mif.tvalid && !mif.tready;
            prev_data  = mif.tdata;
        end
        sif.tvalid = 1'b0;
        tick();
        checks++; if (rcvd != 1000 || q.size() != 0) begin errors++; $display("FAIL rnd_count: got rcvd=%0d left=%0d want 1000/0", rcvd, q.size()); end
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %b want 0", mif.tvalid); end
    endtask

    task automatic test_invalidate;
        fill(8'h11, 8'h22);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
`ifdef AXIS_SKID_BUF_INVALIDATE_EN
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL inv_mvalid: got %b want 0", mif.tvalid); end
        checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL inv_sready: got %b want 1", sif.tready); end
        mif.tready = 1'b1;
        repeat (3) begin
            tick();
            checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL inv_stale: got v=%b d=%h want v=0", mif.tvalid, mif.tdata); end
        end
`else
        checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 8'h11) begin errors++; $display("FAIL inv_off_head: got v=%b d=%h want v=1 d=11", mif.tvalid, mif.tdata); end
        checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL inv_off_sready: got %b want 0", sif.tready); end
        mif.tready = 1'b1;
        tick();
        checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 8'h22) begin errors++; $display("FAIL inv_off_second: got v=%b d=%h want v=1 d=22", mif.tvalid, mif.tdata); end
        tick();
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL inv_off_empty: got %b want 0", mif.tvalid); end
`endif
    endtask

    task automatic test_reset_mid;
        fill(8'h33, 8'h44);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_mvalid: got %b want 0", mif.tvalid); end
        checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL rstmid_sready: got %b want 0", sif.tready); end
        checks++; if (mif.tdata !== 8'h00) begin errors++; $display("FAIL rstmid_mdata: got %h want 00", mif.tdata); end
        tick();
        rst_n      = 1'b1;
        mif.tready = 1'b1;
        tick();
        checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %b want 1", sif.tready); end
        repeat (2) begin
            checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got v=%b d=%h want v=0", mif.tvalid, mif.tdata); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_stream();
        test_backpressure();
        test_random();
        test_invalidate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
